motion_sequencer: RTL and testbench

MOTION_SEQUENCER -- requirements
Module: motion_sequencer

---
 rtl/motion_sequencer_pkg.sv | 47 ++++
 rtl/motion_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_motion_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/motion_sequencer_pkg.sv
// Shared definitions for the motion sequencer.
// Holds the tone-direction command codes, the FSM state encoding, the width of
// the shared down-counter, and small helpers that map a command onto the
// H-bridge direction it needs.
package motion_sequencer_pkg;

   // Command codes produced by the tone-detection front end
   localparam logic [2:0] TD_HOLD    = 3'd0;
   localparam logic [2:0] TD_STOP    = 3'd1;
   localparam logic [2:0] TD_FORWARD = 3'd2;
   localparam logic [2:0] TD_LEFT    = 3'd3;
   localparam logic [2:0] TD_RIGHT   = 3'd4;
   localparam logic [2:0] TD_REVERSE = 3'd5;

   // FSM state encoding, visible on the debug port
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STOPPED = 3'd1,
      ST_DRIVE   = 3'd2,
      ST_DEAD    = 3'd3,
      ST_TIMED   = 3'd4
   } state_t;

   // One counter times both the dead-time and the timed actions
   localparam int COUNT_W = 27;

   // Direction pair {left,right} (1 = forward) a command needs.
   // STOP (and anything unknown) leaves the direction where it is.
   function automatic logic [1:0] target_dir(input logic [2:0] cmd,
                                              input logic [1:0] cur);
      logic [1:0] dir;
      case (cmd)
         TD_FORWARD: dir = 2'b11;
         TD_LEFT:    dir = 2'b01;
         TD_RIGHT:   dir = 2'b10;
         TD_REVERSE: dir = 2'b00;
         default:    dir = cur;
      endcase
      return dir;
   endfunction

   // HOLD and the unused codes 6/7 never count as commands
   function automatic logic is_command(input logic [2:0] code);
      return (code >= TD_STOP) && (code <= TD_REVERSE);
   endfunction

endpackage

// File: rtl/motion_sequencer.sv
// Motion sequencer for a two-motor H-bridge platform.
// Turns edge events on the tone-detection command code into motor enables and
// directions. Any direction flip is preceded by a dead-time with both motors
// off; turns and reverse are timed actions; a one-deep pending slot queues the
// newest command that arrives while a dead-time or timed action is running.
//
// Ports:
//   clk                  system clock
//   rst                  synchronous active-high reset
//   run                  operator arm switch; low forces IDLE
//   toneDir[2:0]         command code from tone detection (TD_* codes)
//   enableToneDetection  high in every state except IDLE
//   motorEn[1:0]         {left,right} motor enables
//   motorDir[1:0]        {left,right} directions, 1 = forward
//   busy                 high while in DEAD or TIMED
//   state[2:0]           current FSM state, for debug
module motion_sequencer
   import motion_sequencer_pkg::*;
#(
   parameter int unsigned TURN_CYCLES    = 50_000_000,
   parameter int unsigned REVERSE_CYCLES = 100_000_000,
   parameter int unsigned DEAD_CYCLES    = 500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [2:0] toneDir,
   output logic       enableToneDetection,
   output logic [1:0] motorEn,
   output logic [1:0] motorDir,
   output logic       busy,
   output logic [2:0] state
);

   // The counter is loaded with N-1 on entry and the state is left in the
   // cycle it reads zero, which gives exactly N cycles in that state.
   localparam logic [COUNT_W-1:0] DEAD_LOAD =
      (DEAD_CYCLES > 0) ? COUNT_W'(DEAD_CYCLES - 1) : '0;
   localparam logic [COUNT_W-1:0] TURN_LOAD =
      (TURN_CYCLES > 0) ? COUNT_W'(TURN_CYCLES - 1) : '0;
   localparam logic [COUNT_W-1:0] REVERSE_LOAD =
      (REVERSE_CYCLES > 0) ? COUNT_W'(REVERSE_CYCLES - 1) : '0;

   state_t              state_q, state_d;
   logic [1:0]          en_q, en_d;
   logic [1:0]          dir_q, dir_d;
   logic                etd_q, etd_d;
   logic                busy_q, busy_d;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic                pending_valid, pending_valid_d;
   logic [2:0]          pending_cmd, pending_cmd_d;
   logic [2:0]          dead_cmd, dead_cmd_d;
   logic [2:0]          prev_dir, prev_dir_d;

   logic                event_hit;
   logic                launch;
   logic                apply;
   logic [2:0]          launch_cmd;

   // Every output and all bookkeeping are registered here; reset wins over
   // everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         en_q          <= 2'b00;
         dir_q         <= 2'b11;
         etd_q         <= 1'b0;
         busy_q        <= 1'b0;
         count_q       <= '0;
         pending_valid <= 1'b0;
         pending_cmd   <= TD_HOLD;
         dead_cmd      <= TD_HOLD;
         prev_dir      <= TD_HOLD;
      end else begin
         state_q       <= state_d;
         en_q          <= en_d;
         dir_q         <= dir_d;
         etd_q         <= etd_d;
         busy_q        <= busy_d;
         count_q       <= count_d;
         pending_valid <= pending_valid_d;
         pending_cmd   <= pending_cmd_d;
         dead_cmd      <= dead_cmd_d;
         prev_dir      <= prev_dir_d;
      end
   end

   // Next-state logic. A command is either "launched" (dead-time inserted
   // when the direction must flip) or "applied" directly, which is what
   // happens at the end of a dead-time.
   always_comb begin
      state_d         = state_q;
      en_d            = en_q;
      dir_d           = dir_q;
      count_d         = count_q;
      pending_valid_d = pending_valid;
      pending_cmd_d   = pending_cmd;
      dead_cmd_d      = dead_cmd;
      prev_dir_d      = toneDir;
      launch          = 1'b0;
      apply           = 1'b0;
      launch_cmd      = TD_STOP;

      event_hit = (toneDir != prev_dir) && is_command(toneDir);

      if (!run) begin
         state_d         = ST_IDLE;
         en_d            = 2'b00;
         count_d         = '0;
         pending_valid_d = 1'b0;
         prev_dir_d      = TD_HOLD;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_STOPPED;
            end
            ST_STOPPED, ST_DRIVE: begin
               if (event_hit) begin
                  launch     = 1'b1;
                  launch_cmd = toneDir;
               end
            end
            ST_DEAD, ST_TIMED: begin
               if (event_hit && (toneDir == TD_STOP)) begin
                  state_d         = ST_STOPPED;
                  en_d            = 2'b00;
                  count_d         = '0;
                  pending_valid_d = 1'b0;
               end else begin
                  // An event in the final cycle still counts as the newest
                  // pending command for the follow-on decision below.
                  if (event_hit) begin
                     pending_valid_d = 1'b1;
                     pending_cmd_d   = toneDir;
                  end
                  if (count_q != '0) begin
                     count_d = count_q - 1'b1;
                  end else if (state_q == ST_DEAD) begin
                     // Motors already off, so the next command goes out
                     // without another dead-time.
                     apply           = 1'b1;
                     launch_cmd      = pending_valid_d ? pending_cmd_d : dead_cmd;
                     pending_valid_d = 1'b0;
                  end else if (pending_valid_d) begin
                     launch          = 1'b1;
                     launch_cmd      = pending_cmd_d;
                     pending_valid_d = 1'b0;
                  end else if (dir_q == 2'b00) begin
                     // Reverse finished: stop in place
                     state_d = ST_STOPPED;
                     en_d    = 2'b00;
                  end else begin
                     // Turn finished: resume forward driving
                     launch     = 1'b1;
                     launch_cmd = TD_FORWARD;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               en_d    = 2'b00;
            end
         endcase

         if (launch && (target_dir(launch_cmd, dir_q) != dir_q)) begin
            state_d    = ST_DEAD;
            en_d       = 2'b00;
            count_d    = DEAD_LOAD;
            dead_cmd_d = launch_cmd;
         end else if (launch || apply) begin
            dir_d = target_dir(launch_cmd, dir_q);
            case (launch_cmd)
               TD_STOP: begin
                  state_d = ST_STOPPED;
                  en_d    = 2'b00;
                  count_d = '0;
               end
               TD_FORWARD: begin
                  state_d = ST_DRIVE;
                  en_d    = 2'b11;
                  count_d = '0;
               end
               TD_REVERSE: begin
                  state_d = ST_TIMED;
                  en_d    = 2'b11;
                  count_d = REVERSE_LOAD;
               end
               default: begin
                  state_d = ST_TIMED;
                  en_d    = 2'b11;
                  count_d = TURN_LOAD;
               end
            endcase
         end
      end

      busy_d = (state_d == ST_DEAD) || (state_d == ST_TIMED);
      etd_d  = (state_d != ST_IDLE);
   end

   assign enableToneDetection = etd_q;
   assign motorEn             = en_q;
   assign motorDir            = dir_q;
   assign busy                = busy_q;
   assign state               = state_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed self-checking bench for motion_sequencer with short timings
// (turn 20, reverse 30, dead-time 4 cycles).
module tb_motion_sequencer;
   import motion_sequencer_pkg::*;

   logic       clk;
   logic       rst;
   logic       run;
   logic [2:0] toneDir;
   logic       enableToneDetection;
   logic [1:0] motorEn;
   logic [1:0] motorDir;
   logic       busy;
   logic [2:0] state;

   int testsRun    = 0;
   int testsFailed = 0;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_STOPPED = 3'd1;
   localparam logic [2:0] S_DRIVE   = 3'd2;
   localparam logic [2:0] S_DEAD    = 3'd3;
   localparam logic [2:0] S_TIMED   = 3'd4;

   motion_sequencer #(
      .TURN_CYCLES(20),
      .REVERSE_CYCLES(30),
      .DEAD_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .run(run),
      .toneDir(toneDir),
      .enableToneDetection(enableToneDetection),
      .motorEn(motorEn),
      .motorDir(motorDir),
      .busy(busy),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      run = 1'b0;
      toneDir = TD_HOLD;
      tick();
      tick();
      rst = 1'b0;
      testsRun++;
      if (state !== S_IDLE || motorEn !== 2'b00 || motorDir !== 2'b11 ||
          enableToneDetection !== 1'b0 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset: state=%0d en=%b dir=%b etd=%b busy=%b, want 0 00 11 0 0",
                  state, motorEn, motorDir, enableToneDetection, busy);
      end
   endtask

   task automatic test_forward();
      run = 1'b1;
      tick();
      testsRun++;
      if (state !== S_STOPPED || motorEn !== 2'b00 || enableToneDetection !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL arm: state=%0d en=%b etd=%b, want 1 00 1",
                  state, motorEn, enableToneDetection);
      end
      toneDir = TD_FORWARD;
      tick();
      testsRun++;
      if (state !== S_DRIVE || motorEn !== 2'b11 || motorDir !== 2'b11 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL forward: state=%0d en=%b dir=%b busy=%b, want 2 11 11 0",
                  state, motorEn, motorDir, busy);
      end
   endtask

   // Starts in DRIVE with toneDir not LEFT; ends in DRIVE with toneDir LEFT
   task automatic test_left_turn();
      toneDir = TD_LEFT;
      for (int i = 0; i < 4; i++) begin
         tick();
         testsRun++;
         if (state !== S_DEAD || motorEn !== 2'b00 || busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL left_dead_in[%0d]: state=%0d en=%b busy=%b, want 3 00 1",
                     i, state, motorEn, busy);
         end
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         testsRun++;
         if (state !== S_TIMED || motorEn !== 2'b11 || motorDir !== 2'b01 || busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL left_turn[%0d]: state=%0d en=%b dir=%b busy=%b, want 4 11 01 1",
                     i, state, motorEn, motorDir, busy);
         end
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         testsRun++;
         if (state !== S_DEAD || motorEn !== 2'b00 || motorDir !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL left_dead_out[%0d]: state=%0d en=%b dir=%b, want 3 00 01",
                     i, state, motorEn, motorDir);
         end
      end
      tick();
      testsRun++;
      if (state !== S_DRIVE || motorEn !== 2'b11 || motorDir !== 2'b11 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL left_resume: state=%0d en=%b dir=%b busy=%b, want 2 11 11 0",
                  state, motorEn, motorDir, busy);
      end
   endtask

   task automatic test_no_retrigger();
      for (int i = 0; i < 3; i++) tick();
      testsRun++;
      if (state !== S_DRIVE || motorEn !== 2'b11 || motorDir !== 2'b11) begin
         testsFailed++;
         $display("[TB] FAIL held_left: state=%0d en=%b dir=%b, want 2 11 11",
                  state, motorEn, motorDir);
      end
      toneDir = TD_HOLD;
      tick();
      testsRun++;
      if (state !== S_DRIVE) begin
         testsFailed++;
         $display("[TB] FAIL hold_code: state=%0d, want 2", state);
      end
      test_left_turn();
   endtask

   task automatic test_reverse_stop();
      toneDir = TD_REVERSE;
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         testsRun++;
         if (state !== S_TIMED || motorEn !== 2'b11 || motorDir !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reverse[%0d]: state=%0d en=%b dir=%b, want 4 11 00",
                     i, state, motorEn, motorDir);
         end
      end
      toneDir = TD_STOP;
      tick();
      testsRun++;
      if (state !== S_STOPPED || motorEn !== 2'b00 || busy !== 1'b0 ||
          motorDir !== 2'b00 || dut.pending_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL stop_preempt: state=%0d en=%b busy=%b dir=%b pend=%b, want 1 00 0 00 0",
                  state, motorEn, busy, motorDir, dut.pending_valid);
      end
   endtask

   // Starts in STOPPED with dir 00
   task automatic test_pending();
      toneDir = TD_LEFT;
      for (int i = 0; i < 4; i++) tick();
      tick();
      testsRun++;
      if (state !== S_TIMED || motorDir !== 2'b01 || motorEn !== 2'b11) begin
         testsFailed++;
         $display("[TB] FAIL pend_turn_start: state=%0d en=%b dir=%b, want 4 11 01",
                  state, motorEn, motorDir);
      end
      toneDir = TD_RIGHT;
      tick();
      toneDir = TD_FORWARD;
      tick();
      testsRun++;
      if (dut.pending_valid !== 1'b1 || dut.pending_cmd !== TD_FORWARD || state !== S_TIMED) begin
         testsFailed++;
         $display("[TB] FAIL pend_latch: valid=%b cmd=%0d state=%0d, want 1 2 4",
                  dut.pending_valid, dut.pending_cmd, state);
      end
      for (int i = 0; i < 17; i++) tick();
      testsRun++;
      if (state !== S_TIMED || motorDir !== 2'b01) begin
         testsFailed++;
         $display("[TB] FAIL pend_turn_last: state=%0d dir=%b, want 4 01", state, motorDir);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         testsRun++;
         if (state !== S_DEAD || motorEn !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL pend_dead[%0d]: state=%0d en=%b, want 3 00", i, state, motorEn);
         end
      end
      tick();
      testsRun++;
      if (state !== S_DRIVE || motorEn !== 2'b11 || motorDir !== 2'b11 ||
          dut.pending_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL pend_forward: state=%0d en=%b dir=%b pend=%b, want 2 11 11 0",
                  state, motorEn, motorDir, dut.pending_valid);
      end
   endtask

   // Starts in DRIVE with toneDir FORWARD
   task automatic test_run_drop_dead();
      toneDir = TD_REVERSE;
      tick();
      tick();
      testsRun++;
      if (state !== S_DEAD) begin
         testsFailed++;
         $display("[TB] FAIL drop_pre: state=%0d, want 3", state);
      end
      run = 1'b0;
      tick();
      testsRun++;
      if (state !== S_IDLE || motorEn !== 2'b00 || enableToneDetection !== 1'b0 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL run_drop: state=%0d en=%b etd=%b busy=%b, want 0 00 0 0",
                  state, motorEn, enableToneDetection, busy);
      end
      run = 1'b1;
      tick();
      testsRun++;
      if (state !== S_STOPPED || motorEn !== 2'b00 || motorDir !== 2'b11) begin
         testsFailed++;
         $display("[TB] FAIL rearm: state=%0d en=%b dir=%b, want 1 00 11",
                  state, motorEn, motorDir);
      end
   endtask

   // Starts in STOPPED with dir 11
   task automatic test_reset_timed();
      toneDir = TD_HOLD;
      tick();
      toneDir = TD_RIGHT;
      for (int i = 0; i < 7; i++) tick();
      testsRun++;
      if (state !== S_TIMED || motorDir !== 2'b10 || motorEn !== 2'b11) begin
         testsFailed++;
         $display("[TB] FAIL right_turn: state=%0d en=%b dir=%b, want 4 11 10",
                  state, motorEn, motorDir);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      testsRun++;
      if (state !== S_IDLE || motorEn !== 2'b00 || motorDir !== 2'b11 ||
          enableToneDetection !== 1'b0 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_timed: state=%0d en=%b dir=%b etd=%b busy=%b, want 0 00 11 0 0",
                  state, motorEn, motorDir, enableToneDetection, busy);
      end
   endtask

   initial begin
      rst = 1'b1;
      run = 1'b0;
      toneDir = TD_HOLD;
      test_reset();
      test_forward();
      test_left_turn();
      test_no_retrigger();
      test_reverse_stop();
      test_pending();
      test_run_drop_dead();
      test_reset_timed();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
